// File: rtl/mem_arbiter_2to1.sv
// Two-master to one-slave arbiter for 36-bit Avalon-MM-style memory buses.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (m0).
module mem_arbiter_2to1 #(
    parameter int AW = 18,
    parameter int DW = 36
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] s0_address,
    input  logic          s0_read,
    input  logic          s0_write,
    input  logic [DW-1:0] s0_writedata,
    output logic [DW-1:0] s0_readdata,
    output logic          s0_waitrequest,
    input  logic [AW-1:0] s1_address,
    input  logic          s1_read,
    input  logic          s1_write,
    input  logic [DW-1:0] s1_writedata,
    output logic [DW-1:0] s1_readdata,
    output logic          s1_waitrequest,
    output logic [AW-1:0] m_address,
    output logic          m_read,
    output logic          m_write,
    output logic [DW-1:0] m_writedata,
    input  logic [DW-1:0] m_readdata,
    input  logic          m_waitrequest
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   s0_req, s1_req;
    logic   tie_to_1;

    assign s0_req = s0_read | s0_write;
    assign s1_req = s1_read | s1_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // last_q holds the master granted most recently; ties go to the other one
    assign tie_to_1 = ~last_q;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && state_d == GNT0) last_d = 1'b0;
        if (state_q == IDLE && state_d == GNT1) last_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    assign tie_to_1 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s0_req && s1_req) state_d = tie_to_1 ? GNT1 : GNT0;
                else if (s0_req)      state_d = GNT0;
                else if (s1_req)      state_d = GNT1;
            end
            GNT0: if (!s0_req || !m_waitrequest) state_d = IDLE;
            GNT1: if (!s1_req || !m_waitrequest) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A simultaneous read+write from a master is forwarded as a write
    always_comb begin
        m_address      = '0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_writedata    = '0;
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        unique case (state_q)
            GNT0: begin
                m_address      = s0_address;
                m_read         = s0_read & ~s0_write;
                m_write        = s0_write;
                m_writedata    = s0_writedata;
                s0_waitrequest = m_waitrequest;
            end
            GNT1: begin
                m_address      = s1_address;
                m_read         = s1_read & ~s1_write;
                m_write        = s1_write;
                m_writedata    = s1_writedata;
                s1_waitrequest = m_waitrequest;
            end
            default: ;
        endcase
    end

    assign s0_readdata = m_readdata;
    assign s1_readdata = m_readdata;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Randomized self-checking bench for mem_arbiter_2to1 with a 16K-word test memory.
// Honours ARB_ROUND_ROBIN_EN to select the expected tie-break rule.
module tb_mem_arbiter_2to1;

    localparam int AW = 18;
    localparam int DW = 36;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, reset;
    logic [AW-1:0] s0_address, s1_address, m_address;
    logic          s0_read, s0_write, s1_read, s1_write;
    logic [DW-1:0] s0_writedata, s1_writedata, m_writedata;
    logic [DW-1:0] s0_readdata, s1_readdata, m_readdata;
    logic          s0_waitrequest, s1_waitrequest;
    logic          m_read, m_write, m_waitrequest;

    mem_arbiter_2to1 #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
        .s0_waitrequest(s0_waitrequest),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
        .s1_waitrequest(s1_waitrequest),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest)
    );

    logic [DW-1:0] mem     [16384];
    logic [DW-1:0] ref_mem [16384];
    int  n_chk, n_pass;
    bit  stall, zwait, watch_s1;
    bit  last_gnt;
    int  order[$];

    assign m_readdata = mem[m_address[13:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Slave: writes land on the accepting edge, read data is combinational
    initial begin
        logic          pw;
        logic [13:0]   pa;
        logic [DW-1:0] pd;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        mem[4] = 36'o123;
        mem[5] = 36'o321;
        mem[6] = 36'o444444;
        mem[8] = 36'o11111;
        m_waitrequest = 1'b1;
        forever begin
            @(negedge clk);
            pw = m_write && !m_waitrequest && reset;
            pa = m_address[13:0];
            pd = m_writedata;
            @(posedge clk);
            if (pw) mem[pa] = pd;
            #1;
            m_waitrequest = stall ? 1'b1 :
                            (zwait ? 1'b0 : ($urandom_range(0, 2) == 0));
        end
    end

    // Reference: an idle cycle with pending requests must be followed by
    // the rule-chosen master owning the slave port.
    initial begin
        bit pend, pr0, pr1, w, q0, q1;
        pend = 0; pr0 = 0; pr1 = 0;
        last_gnt = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 0;
                last_gnt = 1'b1;
            end else begin
                if (watch_s1) check("s1_hold", s1_waitrequest, 1);
                if (pend) begin
                    if (pr0 && pr1) w = RR ? !last_gnt : 1'b0;
                    else            w = pr1;
                    check("gnt_strobe", m_read | m_write, 1);
                    if (!w) begin
                        check("gnt0_addr", m_address, s0_address);
                        check("gnt0_wr", m_write, s0_write);
                        check("gnt0_rd", m_read, s0_read & ~s0_write);
                        check("gnt0_wd", m_writedata, s0_writedata);
                        check("gnt0_wait", s0_waitrequest, m_waitrequest);
                        check("gnt0_other", s1_waitrequest, 1);
                    end else begin
                        check("gnt1_addr", m_address, s1_address);
                        check("gnt1_wr", m_write, s1_write);
                        check("gnt1_rd", m_read, s1_read & ~s1_write);
                        check("gnt1_wd", m_writedata, s1_writedata);
                        check("gnt1_wait", s1_waitrequest, m_waitrequest);
                        check("gnt1_other", s0_waitrequest, 1);
                    end
                    last_gnt = w;
                    pend = 0;
                end
                q0 = s0_read | s0_write;
                q1 = s1_read | s1_write;
                if ((q0 || q1) && !(m_read || m_write)) begin
                    check("arb_w0", s0_waitrequest, 1);
                    check("arb_w1", s1_waitrequest, 1);
                    pend = 1; pr0 = q0; pr1 = q1;
                end
            end
        end
    end

    task automatic drv(input int id, input bit r, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            s0_read = r; s0_write = w; s0_address = a; s0_writedata = d;
        end else begin
            s1_read = r; s1_write = w; s1_address = a; s1_writedata = d;
        end
    endtask

    // Called just after a posedge; returns just after the completing edge
    task automatic xfer(input int id, input bit wr, input bit rb,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] rd;
        int n;
        bit got;
        rd = '0; n = 0; got = 0;
        drv(id, wr ? rb : 1'b1, wr, a, d);
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (((id == 0) ? s0_waitrequest : s1_waitrequest) == 1'b0) begin
                got = 1;
                rd = (id == 0) ? s0_readdata : s1_readdata;
            end
        end
        check("xfer_done", got, 1);
        if (got) begin
            check("xfer_latency", n >= 2, 1);
            if (wr) ref_mem[a[13:0]] = d;
            else    check("xfer_rdata", rd, ref_mem[a[13:0]]);
            order.push_back(id);
        end
        @(posedge clk);
        #1;
        drv(id, 0, 0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] a3 [4];
        bit exp_first;
        n_chk = 0; n_pass = 0;
        stall = 0; zwait = 1; watch_s1 = 0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
        ref_mem[4] = 36'o123;
        ref_mem[5] = 36'o321;
        ref_mem[6] = 36'o444444;
        ref_mem[8] = 36'o11111;
        reset = 1'b0;
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);

        repeat (20) begin
            @(negedge clk);
            check("rst_rd", m_read, 0);
            check("rst_wr", m_write, 0);
            check("rst_w0", s0_waitrequest, 1);
            check("rst_w1", s1_waitrequest, 1);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_addr", m_address, 0);
            check("idle_wd", m_writedata, 0);
            check("idle_w0", s0_waitrequest, 1);
            check("idle_w1", s1_waitrequest, 1);
        end

        @(posedge clk); #1;
        xfer(0, 1, 0, 18'd4, 36'o1234);
        @(negedge clk);
        check("t2_wait_after", s0_waitrequest, 1);
        check("t2_wr_after", m_write, 0);
        check("t2_mem4", mem[4], 36'o1234);

        a3[0] = 18'd5; a3[1] = 18'd6; a3[2] = 18'd0; a3[3] = 18'd4;
        @(posedge clk); #1;
        watch_s1 = 1;
        for (int i = 0; i < 4; i++) xfer(0, 0, 0, a3[i], '0);
        watch_s1 = 0;
        check("t3_ref4", ref_mem[4], 36'o1234);

        exp_first = RR ? !last_gnt : 1'b0;
        order.delete();
        fork
            xfer(0, 1, 0, 18'd4, 36'o7);
            xfer(1, 1, 0, 18'd8, 36'o5);
        join
        check("t4_count", order.size(), 2);
        check("t4_first", order[0], exp_first);
        @(negedge clk);
        check("t4_mem4", mem[4], 36'o7);
        check("t4_mem8", mem[8], 36'o5);

        stall = 1;
        @(posedge clk); #1;
        drv(0, 1, 0, 18'd5, '0);
        repeat (3) @(negedge clk);
        check("ab_granted", m_read, 1);
        #1 drv(0, 0, 0, '0, '0);
        #1;
        check("ab_drop_rd", m_read, 0);
        check("ab_drop_w0", s0_waitrequest, 1);
        @(negedge clk);
        check("ab_idle", m_read | m_write, 0);
        stall = 0; zwait = 0;

        order.delete();
        @(posedge clk); #1;
        fork
            for (int k = 0; k < 12; k++) begin
                xfer(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     18'($urandom_range(0, 255)),
                     {4'($urandom), 32'($urandom)});
                if (!RR) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            for (int k = 0; k < 12; k++)
                xfer(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     18'h2000 | 18'($urandom_range(0, 255)),
                     {4'($urandom), 32'($urandom)});
        join
        check("t5_count", order.size(), 24);
        if (RR)
            for (int i = 0; i < 20; i++)
                check("t5_alternate", order[i + 1], !order[i]);

        stall = 1; zwait = 1;
        @(posedge clk); #1;
        drv(1, 1, 0, 18'd6, '0);
        repeat (3) @(negedge clk);
        check("t6_rd", m_read, 1);
        check("t6_addr", m_address, 6);
        check("t6_w1", s1_waitrequest, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_rd", m_read, 0);
        check("t6_rst_addr", m_address, 0);
        check("t6_rst_w1", s1_waitrequest, 1);
        check("t6_rst_w0", s0_waitrequest, 1);
        drv(1, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
        stall = 0;
        reset = 1'b1;
        order.delete();
        @(posedge clk); #1;
        fork
            xfer(0, 0, 0, 18'd5, '0);
            xfer(1, 0, 0, 18'd6, '0);
        join
        check("t6_count", order.size(), 2);
        check("t6_first", order[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
